hdmi_frame_packer: RTL
======================

Name: hdmi_frame_packer

Overview:
Downstream neighbour of the HDMI input decimation stage. Consumes its frame-gated RGB565 stream (vs, de, 16-bit pixel) and packs 8 pixels into 128-bit words. Each word is tagged with a word-granular DDR address for the channel's frame buffer and queued in a small FIFO. A valid/ready handshake presents the queued words to the multi-channel DDR write arbiter.

Parameters:
H_ACTIVE, 1280, active pixels per line accepted; pixels beyond this are ignored
V_ACTIVE, 720, active lines per frame accepted; lines beyond this are ignored
FIFO_DEPTH, 16, entries in the word FIFO (power of 2, min 4)
ADDR_WIDTH, 28, width of the word address
BASE_ADDR, 0, word address of pixel (0,0) of this channel
LINE_STRIDE, 160, word-address increment per stored line

Ports:
hdmi_pix_clk_in  in  1  pixel clock; the only clock
rst  in  1  synchronous reset, active-high
vs_in  in  1  vertical sync from the decimation stage; rising edge = frame start
de_in  in  1  pixel valid / line active
rgb565_in  in  16  pixel, valid when de_in=1
wr_data  out  128  packed word; pixel 0 in [15:0], pixel 7 in [127:112]
wr_addr  out  ADDR_WIDTH  word address of wr_data
wr_valid  out  1  FIFO non-empty
wr_ready  in  1  arbiter accepts word when wr_valid & wr_ready
frame_start  out  1  one-cycle pulse on the vs_in rising edge
line_done  out  1  one-cycle pulse when a stored line is closed
overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0. FIFO empty. pix_cnt, word_in_line, line_cnt = 0. Line base = BASE_ADDR.
- vs_in and de_in are registered once. Edges are detected on the registered copies.
- vs rising edge (cycle T): frame_start=1 at T+1. pix_cnt, word_in_line, line_cnt and line base are reset to BASE_ADDR. A partially filled word is discarded, not flushed. The FIFO is not cleared; old-frame words continue to drain.
- Pixel accept: de_in=1, line_cnt<V_ACTIVE and pixel column<H_ACTIVE. The pixel is written into slot pix_cnt and pix_cnt increments modulo 8.
- Word push: when slot 7 is filled, {data, line_base+word_in_line} is pushed into the FIFO on the next cycle, and word_in_line increments.
- Latency: 8th pixel sampled at T; wr_valid=1 at T+2 if the FIFO was empty.
- de falling edge on an accepted line:
  - If pix_cnt≠0, unfilled slots are zero-padded and the word is pushed. This flush push takes the same path as a full-word push.
  - line_done pulses 1 cycle.
  - line_cnt increments; line base += LINE_STRIDE.
  - word_in_line and pix_cnt reset to 0.
- Lines with line_cnt≥V_ACTIVE produce no pushes and no line_done.
- Simultaneous vs rising edge and de falling edge: vs wins. No flush, no line_done.
- FIFO:
  - Synchronous, first-word fall-through: wr_data/wr_addr are valid whenever wr_valid=1.
  - Pop on wr_valid & wr_ready.
  - Push when full without a same-cycle pop: the word is dropped and overflow is set. Otherwise full + push + pop succeeds.
  - Pop when empty is ignored.
  - overflow clears only on rst.
- wr_data/wr_addr are held stable while wr_valid=1 and wr_ready=0.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset mid-line or mid-handshake: everything returns to reset values on the next edge. Queued words are lost.

Optional Feature:
HDMI_PACK_DECIM_2X_EN
- Defined: 2:1 downscale in each dimension for quad-view splicing.
  - Only even columns (0, 2, …) of even lines (0, 2, …) are accepted.
  - Odd lines produce no pushes and no line_done, and do not advance the line base.
  - Limits become H_ACTIVE/2 pixels per line and V_ACTIVE/2 stored lines; LINE_STRIDE is unchanged.
- Undefined: every pixel and every line within H_ACTIVE/V_ACTIVE is stored, exactly as above.

Test Plan:
1. Reset, then one frame of 2 lines × 16 pixels, values 0..31, wr_ready=1. Expected:
   - 4 words, first wr_data[15:0]=0 and [127:112]=7.
   - wr_addr = 0, 1, 160, 161.
   - 2 line_done pulses, 1 frame_start pulse.
2. Line of 11 pixels. Expected: second word holds pixels 8..10 in slots 0..2 and zeros in slots 3..7; addr=1.
3. wr_ready=0 for a 160-pixel line (20 words, FIFO_DEPTH=16). Expected: 16 words retained, overflow=1; after wr_ready=1, exactly 16 words drain with addresses 0..15.
4. vs rising edge with pix_cnt=5 mid-line, forced coincident with the de falling edge. Expected: no flush, no line_done; the next frame's first word has addr=BASE_ADDR.
5. Random wr_ready backpressure over a full 1280×720 frame. Expected: 115200 words, addresses strictly increase by the stride pattern, data matches the scoreboard, overflow=0.
6. With HDMI_PACK_DECIM_2X_EN, 4 lines × 32 pixels. Expected: 4 words holding even pixels of lines 0 and 2; addr = 0, 1, 160, 161; 2 line_done pulses.

Source files
------------

// File: rtl/hdmi_frame_packer.sv
// Packs 8 RGB565 pixels per 128-bit word tagged with a frame-buffer word address; optional 2:1 downscale via HDMI_PACK_DECIM_2X_EN.
// Latency: 8th pixel sampled at T -> wr_valid at T+2; words are dropped (sticky overflow) when the FIFO is full.
module hdmi_frame_packer #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_WIDTH  = 28,
    parameter int BASE_ADDR   = 0,
    parameter int LINE_STRIDE = 160
) (
    input  logic                  hdmi_pix_clk_in,
    input  logic                  rst,
    input  logic                  vs_in,
    input  logic                  de_in,
    input  logic [15:0]           rgb565_in,
    output logic [127:0]          wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  frame_start,
    output logic                  line_done,
    output logic                  overflow
);

`ifdef HDMI_PACK_DECIM_2X_EN
    localparam bit DECIM = 1'b1;
`else
    localparam bit DECIM = 1'b0;
`endif

    localparam logic [15:0] H_LIM = 16'(H_ACTIVE);
    localparam logic [15:0] V_LIM = DECIM ? 16'(V_ACTIVE / 2) : 16'(V_ACTIVE);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  vs_r, vs_rr, de_r, de_rr;
    logic [15:0]           pix_r;
    logic [2:0]            pix_cnt;
    logic [15:0]           col_cnt;
    logic [15:0]           line_cnt;
    logic                  line_odd;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] word_in_line;
    logic [127:0]          pack_dat;
    logic                  push_vld;
    logic [127:0]          push_dat;
    logic [ADDR_WIDTH-1:0] push_addr;

    logic vs_rise, de_fall, line_ok, col_ok, accept, line_close;

    assign vs_rise    = vs_r & ~vs_rr;
    assign de_fall    = de_rr & ~de_r;
    assign line_ok    = (line_cnt < V_LIM) & ~(DECIM & line_odd);
    assign col_ok     = (col_cnt < H_LIM) & ~(DECIM & col_cnt[0]);
    assign accept     = de_r & line_ok & col_ok & ~vs_rise;
    assign line_close = de_fall & line_ok & ~vs_rise;

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (rst) begin
            vs_r         <= 1'b0;
            vs_rr        <= 1'b0;
            de_r         <= 1'b0;
            de_rr        <= 1'b0;
            pix_r        <= '0;
            pix_cnt      <= '0;
            col_cnt      <= '0;
            line_cnt     <= '0;
            line_odd     <= 1'b0;
            line_base    <= ADDR_WIDTH'(BASE_ADDR);
            word_in_line <= '0;
            pack_dat     <= '0;
            push_vld     <= 1'b0;
            push_dat     <= '0;
            push_addr    <= '0;
            frame_start  <= 1'b0;
            line_done    <= 1'b0;
        end else begin
            vs_r        <= vs_in;
            vs_rr       <= vs_r;
            de_r        <= de_in;
            de_rr       <= de_r;
            pix_r       <= rgb565_in;
            frame_start <= vs_rise;
            line_done   <= 1'b0;
            push_vld    <= 1'b0;
            if (vs_rise) begin
                // Partial word of the old frame is discarded; queued words still drain.
                pix_cnt      <= '0;
                col_cnt      <= '0;
                line_cnt     <= '0;
                line_odd     <= 1'b0;
                line_base    <= ADDR_WIDTH'(BASE_ADDR);
                word_in_line <= '0;
                pack_dat     <= '0;
            end else begin
                if (de_r && col_cnt != 16'hFFFF)
                    col_cnt <= col_cnt + 16'd1;
                if (accept) begin
                    pix_cnt <= pix_cnt + 3'd1;
                    if (pix_cnt == 3'd7) begin
                        push_vld     <= 1'b1;
                        push_dat     <= {pix_r, pack_dat[111:0]};
                        push_addr    <= line_base + word_in_line;
                        word_in_line <= word_in_line + ADDR_WIDTH'(1);
                        pack_dat     <= '0;
                    end else begin
                        pack_dat[{pix_cnt, 4'b0000} +: 16] <= pix_r;
                    end
                end
                if (de_fall) begin
                    col_cnt  <= '0;
                    line_odd <= DECIM & ~line_odd;
                end
                if (line_close) begin
                    // Unfilled slots are already zero, so the flush pushes pack_dat as-is.
                    if (pix_cnt != 3'd0) begin
                        push_vld  <= 1'b1;
                        push_dat  <= pack_dat;
                        push_addr <= line_base + word_in_line;
                    end
                    line_done    <= 1'b1;
                    line_cnt     <= line_cnt + 16'd1;
                    line_base    <= line_base + ADDR_WIDTH'(LINE_STRIDE);
                    word_in_line <= '0;
                    pix_cnt      <= '0;
                    pack_dat     <= '0;
                end
            end
        end
    end

    logic [127:0]          mem_dat  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  full, do_pop, do_push;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_valid = (count != '0);
    assign do_pop   = wr_valid & wr_ready;
    assign do_push  = push_vld & (~full | do_pop);
    assign wr_data  = wr_valid ? mem_dat[rd_ptr]  : '0;
    assign wr_addr  = wr_valid ? mem_addr[rd_ptr] : '0;

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (do_push) begin
            mem_dat[wr_ptr]  <= push_dat;
            mem_addr[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_vld && full && !do_pop)
                overflow <= 1'b1;
        end
    end

endmodule
